// File: rtl/serial_display_receiver.sv
// Board-side model of a serial display shift register. The serial lines are
// oversampled on clk and MSB-first frames are deserialized. A frame is
// presented on data_out when the latch strobe rises after exactly WIDTH bits.
module serial_display_receiver #(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned IDLE_TIMEOUT = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ser_clk,
  input  logic                          ser_do,
  input  logic                          ser_clr_n,
  input  logic                          ser_pen,
  output logic [WIDTH-1:0]              data_out,
  output logic                          frame_valid,
  output logic                          frame_err,
  output logic                          timeout,
  output logic [$clog2(WIDTH+2)-1:0]    bit_cnt
);

  localparam int unsigned CntW  = $clog2(WIDTH + 2);
  localparam int unsigned IdleW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  localparam logic [CntW-1:0]  CntFull  = CntW'(WIDTH);
  localparam logic [CntW-1:0]  CntSat   = CntW'(WIDTH + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_TIMEOUT - 1);

  // Synchronizer stages; s3 only exists where an edge must be detected.
  logic r_clk_s1, r_clk_s2, r_clk_s3;
  logic r_pen_s1, r_pen_s2, r_pen_s3;
  logic r_clr_s1, r_clr_s2;
  logic r_do_s1,  r_do_s2;

  logic [WIDTH-1:0] r_shreg_q, r_shreg_d;
  logic [WIDTH-1:0] r_data_q,  r_data_d;
  logic [CntW-1:0]  r_cnt_q,   r_cnt_d;
  logic [IdleW-1:0] r_idle_q,  r_idle_d;
  logic             r_valid_q, r_valid_d;
  logic             r_err_q,   r_err_d;
  logic             r_tmo_q,   r_tmo_d;

  logic w_shift;
  logic w_latch;
  logic w_clear;

  assign w_shift = r_clk_s2 & ~r_clk_s3;
  assign w_latch = r_pen_s2 & ~r_pen_s3;
  assign w_clear = ~r_clr_s2;

  // Two-flop synchronizers plus edge-detect history; ser_do shares the delay of ser_clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s1 <= 1'b0;
      r_clk_s2 <= 1'b0;
      r_clk_s3 <= 1'b0;
      r_pen_s1 <= 1'b0;
      r_pen_s2 <= 1'b0;
      r_pen_s3 <= 1'b0;
      r_clr_s1 <= 1'b1;
      r_clr_s2 <= 1'b1;
      r_do_s1  <= 1'b0;
      r_do_s2  <= 1'b0;
    end else begin
      r_clk_s1 <= ser_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_pen_s1 <= ser_pen;
      r_pen_s2 <= r_pen_s1;
      r_pen_s3 <= r_pen_s2;
      r_clr_s1 <= ser_clr_n;
      r_clr_s2 <= r_clr_s1;
      r_do_s1  <= ser_do;
      r_do_s2  <= r_do_s1;
    end
  end

  // Next-state: clear > latch > timeout, with the shift applied before the latch looks at it.
  always_comb begin
    r_shreg_d = r_shreg_q;
    r_data_d  = r_data_q;
    r_cnt_d   = r_cnt_q;
    r_idle_d  = r_idle_q;
    r_valid_d = 1'b0;
    r_err_d   = 1'b0;
    r_tmo_d   = 1'b0;

    if (w_clear) begin
      r_shreg_d = '0;
      r_cnt_d   = '0;
      r_idle_d  = '0;
    end else begin
      if (w_shift) begin
        r_shreg_d = {r_shreg_q[WIDTH-2:0], r_do_s2};
        r_cnt_d   = (r_cnt_q == CntSat) ? CntSat : r_cnt_q + 1'b1;
        r_idle_d  = '0;
      end else if (r_cnt_q != '0) begin
        r_idle_d = r_idle_q + 1'b1;
      end else begin
        r_idle_d = '0;
      end

      if (w_latch) begin
        if (r_cnt_d == CntFull) begin
          r_data_d  = r_shreg_d;
          r_valid_d = 1'b1;
        end else begin
          r_err_d = 1'b1;
        end
        r_cnt_d  = '0;
        r_idle_d = '0;
      end else if (!w_shift && (r_cnt_q != '0) && (r_idle_q == IdleLast)) begin
        // Partial frame abandoned by the transmitter.
        r_cnt_d  = '0;
        r_idle_d = '0;
        r_tmo_d  = 1'b1;
      end
    end
  end

  // Frame state and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg_q <= '0;
      r_data_q  <= '0;
      r_cnt_q   <= '0;
      r_idle_q  <= '0;
      r_valid_q <= 1'b0;
      r_err_q   <= 1'b0;
      r_tmo_q   <= 1'b0;
    end else begin
      r_shreg_q <= r_shreg_d;
      r_data_q  <= r_data_d;
      r_cnt_q   <= r_cnt_d;
      r_idle_q  <= r_idle_d;
      r_valid_q <= r_valid_d;
      r_err_q   <= r_err_d;
      r_tmo_q   <= r_tmo_d;
    end
  end

  assign data_out    = r_data_q;
  assign frame_valid = r_valid_q;
  assign frame_err   = r_err_q;
  assign timeout     = r_tmo_q;
  assign bit_cnt     = r_cnt_q;

endmodule

// File: tb/tb_serial_display_receiver.sv
// Directed bench for serial_display_receiver with WIDTH=16, IDLE_TIMEOUT=32.
module tb_serial_display_receiver;

  localparam int unsigned W  = 16;
  localparam int unsigned IT = 32;
  localparam int unsigned CW = $clog2(W + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          ser_clk;
  logic          ser_do;
  logic          ser_clr_n;
  logic          ser_pen;
  logic [W-1:0]  data_out;
  logic          frame_valid;
  logic          frame_err;
  logic          timeout;
  logic [CW-1:0] bit_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  int nv, ne, nt, nov, fv;

  serial_display_receiver #(
    .WIDTH       (W),
    .IDLE_TIMEOUT(IT)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .ser_clk    (ser_clk),
    .ser_do     (ser_do),
    .ser_clr_n  (ser_clr_n),
    .ser_pen    (ser_pen),
    .data_out   (data_out),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .timeout    (timeout),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit: data set up 2 clk before the rise, clock high 4, low 4.
  task automatic send_bit(input logic b);
    ser_do = b;
    repeat (2) tick();
    ser_clk = 1'b1;
    repeat (4) tick();
    ser_clk = 1'b0;
    repeat (2) tick();
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(val[i]);
  endtask

  // Watch pulses for n cycles; fv is the 1-based cycle of the first frame_valid.
  task automatic watch(input int n, output int o_nv, output int o_ne, output int o_nt,
                       output int o_nov, output int o_fv);
    o_nv = 0; o_ne = 0; o_nt = 0; o_nov = 0; o_fv = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (frame_valid) begin
        o_nv++;
        if (o_fv == 0) o_fv = i;
      end
      if (frame_err) o_ne++;
      if (timeout) o_nt++;
      if (int'(frame_valid) + int'(frame_err) + int'(timeout) > 1) o_nov++;
    end
  endtask

  task automatic pen_pulse();
    ser_pen = 1'b1;
    watch(5, nv, ne, nt, nov, fv);
    ser_pen = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; ser_clk = 1'b0; ser_do = 1'b0; ser_clr_n = 1'b1; ser_pen = 1'b0;
    repeat (3) tick();
    check_eq("rst_data", data_out, 0);
    check_eq("rst_cnt", bit_cnt, 0);
    check_eq("rst_pulses", {frame_valid, frame_err, timeout}, 0);
    rst = 1'b0;
    repeat (3) tick();

    // Full frame.
    send_bits(32'hA5C3, 16);
    check_eq("a5c3_cnt", bit_cnt, 16);
    pen_pulse();
    check_eq("a5c3_nvalid", nv, 1);
    check_eq("a5c3_latency", fv, 3);
    check_eq("a5c3_nerr", ne, 0);
    check_eq("a5c3_data", data_out, 16'hA5C3);
    check_eq("a5c3_cnt0", bit_cnt, 0);

    // Short frame.
    send_bits(32'h1234, 15);
    check_eq("short_cnt", bit_cnt, 15);
    pen_pulse();
    check_eq("short_nerr", ne, 1);
    check_eq("short_nvalid", nv, 0);
    check_eq("short_data", data_out, 16'hA5C3);

    // Overrun: count saturates at 17.
    send_bits(32'h1FFFE, 17);
    check_eq("over_cnt", bit_cnt, 17);
    pen_pulse();
    check_eq("over_nerr", ne, 1);
    check_eq("over_data", data_out, 16'hA5C3);
    check_eq("over_cnt0", bit_cnt, 0);

    // Clear mid-frame, then a fresh frame.
    send_bits(32'hFF, 8);
    ser_clr_n = 1'b0;
    repeat (3) tick();
    check_eq("clr_cnt", bit_cnt, 0);
    ser_clr_n = 1'b1;
    repeat (3) tick();
    send_bits(32'h1234, 16);
    pen_pulse();
    check_eq("clr_nvalid", nv, 1);
    check_eq("clr_data", data_out, 16'h1234);

    // Latch strobe while clear is asserted: no pulses.
    send_bits(32'h5555, 16);
    ser_clr_n = 1'b0;
    repeat (3) tick();
    pen_pulse();
    check_eq("clrpen_pulses", nv + ne + nt, 0);
    check_eq("clrpen_data", data_out, 16'h1234);
    ser_clr_n = 1'b1;
    repeat (3) tick();

    // Idle timeout on a partial frame.
    send_bits(32'h15, 5);
    watch(40, nv, ne, nt, nov, fv);
    check_eq("tmo_count", nt, 1);
    check_eq("tmo_other", nv + ne, 0);
    check_eq("tmo_cnt", bit_cnt, 0);
    send_bits(32'hBEEF, 16);
    pen_pulse();
    check_eq("beef_nvalid", nv, 1);
    check_eq("beef_data", data_out, 16'hBEEF);

    // Last ser_clk rise and ser_pen rise in the same cycle.
    send_bits(32'hCAFE >> 1, 15);
    ser_do = 1'b0;
    repeat (2) tick();
    ser_clk = 1'b1;
    ser_pen = 1'b1;
    watch(5, nv, ne, nt, nov, fv);
    ser_clk = 1'b0;
    ser_pen = 1'b0;
    repeat (3) tick();
    check_eq("same_nvalid", nv, 1);
    check_eq("same_nerr", ne, 0);
    check_eq("same_data", data_out, 16'hCAFE);

    // Reset mid-frame.
    send_bits(32'h7, 3);
    rst = 1'b1;
    tick();
    check_eq("mrst_data", data_out, 0);
    check_eq("mrst_cnt", bit_cnt, 0);
    check_eq("mrst_pulses", {frame_valid, frame_err, timeout}, 0);
    rst = 1'b0;
    repeat (3) tick();
    send_bits(32'h0F0F, 16);
    pen_pulse();
    check_eq("post_nvalid", nv, 1);
    check_eq("post_data", data_out, 16'h0F0F);
    check_eq("post_overlap", nov, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Hard stop in case stimulus ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
